// File: rtl/prio_mux27_sched_if.sv
// Bundles the frame-control and grant signals of prio_mux27_sched.
// Signals:
//   start    : frame start request, sampled each clk
//   req      : 27-bit occupancy mask, bit k set means mux input k holds a candidate
//   stall    : downstream hold, suppresses new grants
//   sel      : registered mux select for prio_mux27
//   sel_vld  : sel carries a new grant this cycle
//   out_valid: mux output o is a granted candidate this cycle
//   out_idx  : input index that produced o while out_valid=1
//   busy     : scheduler is not idle
//   done     : one-cycle frame-complete pulse
//   trunc    : frame ended on the grant limit, valid while done=1
//   busy_err : one-cycle pulse, start seen while busy
// master drives start/req/stall; slave (the scheduler) drives the rest.
interface prio_mux27_sched_if;
  logic        start;
  logic [26:0] req;
  logic        stall;
  logic [4:0]  sel;
  logic        sel_vld;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;
  logic        trunc;
  logic        busy_err;

  modport master (
    output start, req, stall,
    input  sel, sel_vld, out_valid, out_idx, busy, done, trunc, busy_err
  );

  modport slave (
    input  start, req, stall,
    output sel, sel_vld, out_valid, out_idx, busy, done, trunc, busy_err
  );
endinterface

// File: rtl/prio_mux27_sched.sv
// Frame scheduler for a 27-input mux: captures an occupancy mask on start and
// issues one grant per cycle in ascending index order, up to MAX_OUT grants,
// then reports completion. A one-cycle pipeline marks the mux output valid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : prio_mux27_sched_if.slave (start/req/stall in; sel, sel_vld,
//           out_valid, out_idx, busy, done, trunc, busy_err out)
module prio_mux27_sched #(
  parameter int unsigned MAX_OUT = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prio_mux27_sched_if.slave     bus
);

  localparam int unsigned N_IN  = 27;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 5;

  // Clamp into the legal 1..27 range so a bad override cannot stall a frame.
  localparam int unsigned MAX_CLAMP = (MAX_OUT < 1) ? 1 : ((MAX_OUT > N_IN) ? N_IN : MAX_OUT);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CLAMP);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [N_IN-1:0]  pending_q,   pending_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [IDX_W-1:0] sel_q,       sel_d;
  logic             sel_vld_q,   sel_vld_d;
  logic             trunc_q,     trunc_d;
  logic             busy_err_q,  busy_err_d;
  logic             busy_q,      done_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W-1:0] low_idx;

  // Lowest set bit of pending; descending scan so the lowest index wins.
  always_comb begin
    low_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    count_d    = count_q;
    sel_d      = sel_q;
    sel_vld_d  = 1'b0;
    trunc_d    = trunc_q;
    busy_err_d = bus.start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pending_d = bus.req;
          count_d   = '0;
          trunc_d   = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (pending_q == '0) begin
          state_d = DRAIN;
        end else if (!bus.stall) begin
          sel_d     = low_idx;
          sel_vld_d = 1'b1;
          // x & (x-1) clears exactly the lowest set bit.
          pending_d = pending_q & (pending_q - N_IN'(1));
          count_d   = count_q + CNT_W'(1);
          if (pending_d == '0) begin
            state_d = DRAIN;
          end else if (count_d == MAX_CNT) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      count_q     <= '0;
      sel_q       <= '0;
      sel_vld_q   <= 1'b0;
      trunc_q     <= 1'b0;
      busy_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      sel_q       <= sel_d;
      sel_vld_q   <= sel_vld_d;
      trunc_q     <= trunc_d;
      busy_err_q  <= busy_err_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      // Mux has one cycle of latency; this stage tracks its output.
      out_valid_q <= sel_vld_q;
      out_idx_q   <= sel_q;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_vld   = sel_vld_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.trunc     = trunc_q;
  assign bus.busy_err  = busy_err_q;

endmodule

// File: tb/tb_prio_mux27_sched.sv
module tb_prio_mux27_sched;

  typedef struct packed {
    logic       is_done;
    logic [4:0] val;
  } ent_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   be_cnt;
  logic mon_en;

  ent_t       oq0[$];
  ent_t       oq4[$];
  logic [4:0] sq0[$];
  logic [4:0] sq4[$];

  prio_mux27_sched_if if0();
  prio_mux27_sched_if if4();

  prio_mux27_sched #(.MAX_OUT(27)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  prio_mux27_sched #(.MAX_OUT(4))  u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_g(input int w, input logic [4:0] k);
    ent_t e;
    e.is_done = 1'b0;
    e.val     = k;
    if (w == 0) begin sq0.push_back(k); oq0.push_back(e); end
    else        begin sq4.push_back(k); oq4.push_back(e); end
  endtask

  task automatic push_d(input int w, input logic ov, input logic tr);
    ent_t e;
    e.is_done = 1'b1;
    e.val     = {3'b000, ov, tr};
    if (w == 0) oq0.push_back(e);
    else        oq4.push_back(e);
  endtask

  // Monitor for one instance: pops expectations whenever the DUT presents output.
  task automatic mon(input int w, input logic sv, input logic [4:0] s,
                     input logic ov, input logic [4:0] oi,
                     input logic dn, input logic tr);
    ent_t       e;
    logic [4:0] es;
    int         qs;
    if (sv) begin
      qs = (w == 0) ? sq0.size() : sq4.size();
      if (qs == 0) check($sformatf("sel_unexpected[%0d]", w), {27'd0, s}, 32'hFFFF_FFFF);
      else begin
        es = (w == 0) ? sq0.pop_front() : sq4.pop_front();
        check($sformatf("sel[%0d]", w), {27'd0, s}, {27'd0, es});
      end
    end
    if (ov) begin
      qs = (w == 0) ? oq0.size() : oq4.size();
      if (qs == 0) check($sformatf("out_unexpected[%0d]", w), {27'd0, oi}, 32'hFFFF_FFFF);
      else begin
        e = (w == 0) ? oq0.pop_front() : oq4.pop_front();
        check($sformatf("out_idx[%0d]", w), {26'd0, 1'b0, oi}, {26'd0, e.is_done, e.val});
      end
    end
    if (dn) begin
      qs = (w == 0) ? oq0.size() : oq4.size();
      if (qs == 0) check($sformatf("done_unexpected[%0d]", w), 32'd1, 32'd0);
      else begin
        e = (w == 0) ? oq0.pop_front() : oq4.pop_front();
        check($sformatf("done_ov_trunc[%0d]", w), {26'd0, 1'b1, 3'b000, ov, tr}, {26'd0, e.is_done, e.val});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, if0.sel_vld, if0.sel, if0.out_valid, if0.out_idx, if0.done, if0.trunc);
      mon(1, if4.sel_vld, if4.sel, if4.out_valid, if4.out_idx, if4.done, if4.trunc);
      if (if0.busy_err) be_cnt++;
    end
  end

  // Start pulse; req is scrambled right after capture to show it is ignored.
  task automatic do_start(input int w, input logic [26:0] r);
    @(negedge clk);
    if (w == 0) begin if0.start = 1'b1; if0.req = r; end
    else        begin if4.start = 1'b1; if4.req = r; end
    @(negedge clk);
    if (w == 0) begin if0.start = 1'b0; if0.req = ~r; end
    else        begin if4.start = 1'b0; if4.req = ~r; end
  endtask

  task automatic wait_done(input int w, input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if ((w == 0) ? if0.done : if4.done) found = 1'b1;
    end
    if (!found) check({nm, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs0();
    return {17'd0, if0.sel, if0.sel_vld, if0.out_valid, if0.out_idx,
            if0.busy, if0.done, if0.trunc, if0.busy_err};
  endfunction

  initial begin
    int n_busy;
    int d_at;
    total  = 0;
    bad    = 0;
    be_cnt = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    if0.start = 1'b0; if0.req = '0; if0.stall = 1'b0;
    if4.start = 1'b0; if4.req = '0; if4.stall = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_u0", outs0(), 32'd0);
    check("reset_outs_u4", {17'd0, if4.sel, if4.sel_vld, if4.out_valid, if4.out_idx,
                            if4.busy, if4.done, if4.trunc, if4.busy_err}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic frame: bits 0,2,5.
    push_g(0, 5'd0); push_g(0, 5'd2); push_g(0, 5'd5); push_d(0, 1'b1, 1'b0);
    do_start(0, 27'h0000025);
    wait_done(0, "basic");

    // Empty frame: SCAN, DRAIN, DONE only.
    push_d(0, 1'b0, 1'b0);
    do_start(0, 27'h0);
    n_busy = 0;
    d_at   = -1;
    for (int i = 0; i < 6; i++) begin
      if (if0.busy) n_busy++;
      if (if0.done) d_at = i;
      @(negedge clk);
    end
    check("empty_busy_cycles", 32'(n_busy), 32'd3);
    check("empty_done_offset", 32'(d_at), 32'd2);

    // Truncation on the MAX_OUT=4 instance.
    push_g(1, 5'd0); push_g(1, 5'd1); push_g(1, 5'd2); push_g(1, 5'd3); push_d(1, 1'b1, 1'b1);
    do_start(1, 27'h7FFFFFF);
    wait_done(1, "trunc4");

    // All 27 inputs on the full instance: no truncation.
    for (int k = 0; k < 27; k++) push_g(0, 5'(k));
    push_d(0, 1'b1, 1'b0);
    do_start(0, 27'h7FFFFFF);
    wait_done(0, "full27");

    // Stall for two cycles after the first grant.
    push_g(0, 5'd0); push_g(0, 5'd1); push_g(0, 5'd26); push_d(0, 1'b1, 1'b0);
    do_start(0, 27'h4000003);
    @(negedge clk);
    check("stall_first_grant", {26'd0, if0.sel_vld, if0.sel}, {26'd0, 1'b1, 5'd0});
    if0.stall = 1'b1;
    @(negedge clk);
    check("stall_hold1", {26'd0, if0.sel_vld, if0.sel}, {26'd0, 1'b0, 5'd0});
    @(negedge clk);
    check("stall_hold2", {26'd0, if0.sel_vld, if0.sel}, {26'd0, 1'b0, 5'd0});
    if0.stall = 1'b0;
    wait_done(0, "stall");

    // Start reasserted during SCAN.
    push_g(0, 5'd0); push_g(0, 5'd2); push_g(0, 5'd5); push_d(0, 1'b1, 1'b0);
    do_start(0, 27'h0000025);
    if0.start = 1'b1;
    if0.req   = 27'h7FFFFFF;
    @(negedge clk);
    if0.start = 1'b0;
    check("busy_err_pulse", {31'd0, if0.busy_err}, 32'd1);
    @(negedge clk);
    check("busy_err_clear", {31'd0, if0.busy_err}, 32'd0);
    wait_done(0, "busy_err");

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    do_start(0, 27'h00000FF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outs", outs0(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_idle", {30'd0, if0.busy, if0.done}, 32'd0);
    end
    sq0.delete();
    oq0.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) push_g(0, 5'(k));
    push_d(0, 1'b1, 1'b0);
    do_start(0, 27'h00000FF);
    wait_done(0, "replay");

    check("queues_drained", 32'(sq0.size() + oq0.size() + sq4.size() + oq4.size()), 32'd0);
    check("busy_err_count", 32'(be_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
